// File: rtl/w_flush_tracker.sv
// Write-side tracker for the per-WID W-beat buffers: steers W beats to slots, fires flush, orders drain.
// Optional W_BEFORE_AW_EN lets a W beat open a slot ahead of its AW.
module w_flush_tracker #(
  parameter int NUM_FIFO = 4,
  parameter int ID_W     = 11,
  parameter int LEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [ID_W-1:0]     aw_id_i,
  input  logic [LEN_W-1:0]    aw_len_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [ID_W-1:0]     w_id_i,
  input  logic                w_last_i,
  input  logic [NUM_FIFO-1:0] slot_ready_i,
  output logic [NUM_FIFO-1:0] slot_push_o,
  output logic [NUM_FIFO-1:0] slot_flush_o,
  input  logic [NUM_FIFO-1:0] slot_done_i,
  output logic [NUM_FIFO-1:0] slot_stall_o,
  output logic                last_err_o
);
  localparam int IW = $clog2(NUM_FIFO);
  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  typedef enum logic [1:0] {S_FREE = 2'd0, S_COLLECT = 2'd1, S_FLUSH = 2'd2} st_e;

  st_e                 st_q   [NUM_FIFO];
  st_e                 st_d   [NUM_FIFO];
  logic [ID_W-1:0]     id_q   [NUM_FIFO];
  logic [ID_W-1:0]     id_d   [NUM_FIFO];
  logic [LEN_W-1:0]    len_q  [NUM_FIFO];
  logic [LEN_W-1:0]    len_d  [NUM_FIFO];
  logic [LEN_W:0]      cnt_q  [NUM_FIFO];
  logic [LEN_W:0]      cnt_d  [NUM_FIFO];
  logic [NUM_FIFO-1:0] has_aw_q, has_aw_d;
  logic [NUM_FIFO-1:0] flush_q, flush_d;
  logic                last_err_q, last_err_d;
  logic [IW-1:0]       ord_q  [NUM_FIFO];
  logic [IW-1:0]       ord_d  [NUM_FIFO];
  logic [IW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [IW:0]         qcnt_q, qcnt_d;

  logic                free_any, aw_dup, aw_att, w_hit, w_room, w_alloc;
  logic [IW-1:0]       free_idx, att_idx, w_idx, w_tgt;
  logic                aw_rdy, aw_acc, aw_new, w_rdy, w_acc, rel;
  logic [NUM_FIFO-1:0] push;
`ifdef W_BEFORE_AW_EN
  logic                w_busy;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FIFO; i++) begin
        st_q[i]  <= S_FREE;
        id_q[i]  <= '0;
        len_q[i] <= '0;
        cnt_q[i] <= '0;
        ord_q[i] <= '0;
      end
      has_aw_q   <= '0;
      flush_q    <= '0;
      last_err_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      qcnt_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_FIFO; i++) begin
        st_q[i]  <= st_d[i];
        id_q[i]  <= id_d[i];
        len_q[i] <= len_d[i];
        cnt_q[i] <= cnt_d[i];
        ord_q[i] <= ord_d[i];
      end
      has_aw_q   <= has_aw_d;
      flush_q    <= flush_d;
      last_err_q <= last_err_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      qcnt_q     <= qcnt_d;
    end
  end

  // Slot lookup; descending scan so the lowest-index hit wins.
  always_comb begin : decode
    free_any = 1'b0;
    free_idx = '0;
    aw_dup   = 1'b0;
    aw_att   = 1'b0;
    att_idx  = '0;
    w_hit    = 1'b0;
    w_idx    = '0;
`ifdef W_BEFORE_AW_EN
    w_busy   = 1'b0;
`endif
    for (int i = NUM_FIFO-1; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end else begin
        if (id_q[i] == aw_id_i) begin
          aw_dup = 1'b1;
`ifdef W_BEFORE_AW_EN
          if (st_q[i] == S_COLLECT && !has_aw_q[i]) begin
            aw_att  = 1'b1;
            att_idx = IW'(i);
          end
`endif
        end
        if (id_q[i] == w_id_i) begin
`ifdef W_BEFORE_AW_EN
          w_busy = 1'b1;
`endif
          if (st_q[i] == S_COLLECT) begin
            w_hit = 1'b1;
            w_idx = IW'(i);
          end
        end
      end
    end
    // Without an AW the length is unknown, so only counter saturation limits intake.
    w_room = has_aw_q[w_idx] ? (cnt_q[w_idx] < ({1'b0, len_q[w_idx]} + CNT_ONE))
                             : (cnt_q[w_idx] != '1);
    aw_rdy = !rst && (aw_att || (free_any && !aw_dup));
    aw_acc = aw_valid_i && aw_rdy;
    aw_new = aw_acc && !aw_att;
`ifdef W_BEFORE_AW_EN
    w_alloc = !w_hit && free_any && !w_busy && !aw_new;
`else
    w_alloc = 1'b0;
`endif
    w_tgt = w_hit ? w_idx : free_idx;
    w_rdy = !rst && ((w_hit && slot_ready_i[w_idx] && w_room) ||
                     (w_alloc && slot_ready_i[free_idx]));
    w_acc = w_valid_i && w_rdy;
    push  = '0;
    push[w_tgt] = w_acc;
    rel = (qcnt_q != '0) && (st_q[ord_q[head_q]] == S_FLUSH) && slot_done_i[ord_q[head_q]];
  end

  always_comb begin : next_state
    has_aw_d   = has_aw_q;
    flush_d    = '0;
    last_err_d = last_err_q;
    for (int i = 0; i < NUM_FIFO; i++) begin
      st_d[i]  = st_q[i];
      id_d[i]  = id_q[i];
      len_d[i] = len_q[i];
      cnt_d[i] = cnt_q[i];
      ord_d[i] = ord_q[i];
    end
    for (int i = 0; i < NUM_FIFO; i++) begin
      case (st_q[i])
        S_FREE: begin
          if (aw_new && free_idx == IW'(i)) begin
            st_d[i]     = S_COLLECT;
            id_d[i]     = aw_id_i;
            len_d[i]    = aw_len_i;
            cnt_d[i]    = '0;
            has_aw_d[i] = 1'b1;
          end else if (push[i]) begin
            st_d[i]     = S_COLLECT;
            id_d[i]     = w_id_i;
            cnt_d[i]    = CNT_ONE;
            has_aw_d[i] = 1'b0;
          end
        end
        S_COLLECT: begin
          if (push[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
            if (has_aw_q[i] && (w_last_i != (cnt_q[i] == {1'b0, len_q[i]})))
              last_err_d = 1'b1;
          end
          if (aw_att && att_idx == IW'(i)) begin
            len_d[i]    = aw_len_i;
            has_aw_d[i] = 1'b1;
            if (cnt_d[i] > ({1'b0, aw_len_i} + CNT_ONE))
              last_err_d = 1'b1;
          end
          if (has_aw_d[i] && cnt_d[i] >= ({1'b0, len_d[i]} + CNT_ONE)) begin
            st_d[i]    = S_FLUSH;
            flush_d[i] = 1'b1;
          end
        end
        S_FLUSH: begin
          if (rel && ord_q[head_q] == IW'(i))
            st_d[i] = S_FREE;
        end
        default: st_d[i] = S_FREE;
      endcase
    end
    head_d = head_q;
    tail_d = tail_q;
    if (aw_acc) begin
      ord_d[tail_q] = aw_att ? att_idx : free_idx;
      tail_d        = tail_q + IW'(1);
    end
    if (rel)
      head_d = head_q + IW'(1);
    qcnt_d = qcnt_q + (IW+1)'(aw_acc) - (IW+1)'(rel);
  end

  always_comb begin : outputs
    aw_ready_o   = aw_rdy;
    w_ready_o    = w_rdy;
    slot_push_o  = push;
    slot_flush_o = flush_q;
    last_err_o   = last_err_q;
    slot_stall_o = '1;
    if (!rst && qcnt_q != '0)
      slot_stall_o[ord_q[head_q]] = 1'b0;
  end

endmodule
